// File: rtl/apb_pkg.sv
// Shared definitions for the APB requester.
//   apb_state_e : requester FSM states (IDLE -> SETUP -> ACCESS)
//   APB_ADDR_W  : default PADDR / command address width
//   APB_DATA_W  : default PWDATA / PRDATA / command data width
//   apb_rsp_t   : completion record (read data, error, watchdog abort)
package apb_pkg;

  localparam int unsigned APB_ADDR_W = 32;
  localparam int unsigned APB_DATA_W = 32;

  typedef enum logic [1:0] {
    APB_IDLE,
    APB_SETUP,
    APB_ACCESS
  } apb_state_e;

  typedef struct packed {
    logic [APB_DATA_W-1:0] rdata;
    logic                  err;
    logic                  tout;
  } apb_rsp_t;

endpackage

// File: rtl/apb_watchdog.sv
// ACCESS-phase wait-state watchdog.
//   clk, rst  : clock, synchronous active-high reset
//   i_load    : clear the count (asserted the cycle before ACCESS starts)
//   i_en      : this cycle is an ACCESS cycle with PREADY low
//   o_expired : this cycle is the TIMEOUT-th low-PREADY ACCESS cycle
// TIMEOUT = 0 disables the watchdog (o_expired never asserts).
module apb_watchdog #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_en,
  output logic o_expired
);

  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= '0;
    end else if (i_en && (TIMEOUT > 0) && (r_cnt != CW'(TIMEOUT))) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // r_cnt holds the low cycles already seen, so the current low cycle is
  // the TIMEOUT-th one when r_cnt == TIMEOUT-1.
  assign o_expired = (TIMEOUT > 0) && i_en && (r_cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/apb_master.sv
// Single-transaction APB requester.
//   clk, rst                         : clock, synchronous active-high reset
//   cmd_valid/cmd_ready              : command handshake
//   cmd_write/cmd_addr/cmd_wdata     : command direction, address, write data
//   rsp_valid                        : one-cycle completion strobe
//   rsp_rdata/rsp_err/rsp_tout       : read data, error, watchdog abort (held between strobes)
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA : APB request signals (registered)
//   PREADY/PRDATA/PSLVERR            : APB completer response, sampled in ACCESS only
module apb_master
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W  = APB_ADDR_W,
  parameter int unsigned DATA_W  = APB_DATA_W,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_tout,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic              PREADY,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PSLVERR
);

  apb_state_e r_state;

  logic w_wd_load;
  logic w_wd_en;
  logic w_wd_expired;

  assign w_wd_load = (r_state == APB_SETUP);
  assign w_wd_en   = (r_state == APB_ACCESS) && !PREADY;

  apb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_wd_load),
    .i_en      (w_wd_en),
    .o_expired (w_wd_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= APB_IDLE;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      rsp_tout  <= 1'b0;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
    end else begin
      rsp_valid <= 1'b0;
      unique case (r_state)
        APB_IDLE: begin
          if (cmd_valid) begin
            PWRITE    <= cmd_write;
            PADDR     <= cmd_addr;
            PWDATA    <= cmd_write ? cmd_wdata : '0;
            PSEL      <= 1'b1;
            cmd_ready <= 1'b0;
            r_state   <= APB_SETUP;
          end
        end
        APB_SETUP: begin
          PENABLE <= 1'b1;
          r_state <= APB_ACCESS;
        end
        APB_ACCESS: begin
          // PREADY is tested first so a completion on the limit cycle wins.
          if (PREADY) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= PWRITE ? '0 : PRDATA;
            rsp_err   <= PSLVERR;
            rsp_tout  <= 1'b0;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            cmd_ready <= 1'b1;
            r_state   <= APB_IDLE;
          end else if (w_wd_expired) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
            rsp_tout  <= 1'b1;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            cmd_ready <= 1'b1;
            r_state   <= APB_IDLE;
          end
        end
        default: begin
          PSEL      <= 1'b0;
          PENABLE   <= 1'b0;
          cmd_ready <= 1'b1;
          r_state   <= APB_IDLE;
        end
      endcase
    end
  end

endmodule
